// File: rtl/mips_pkg.sv
// Shared pipeline definitions: forwarding select codes, register-address and
// counter widths, and the shadow slot record kept for each later stage.
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int CNT_W      = 16;

    // Forwarding mux select codes for the 3:1 EX-stage operand muxes.
    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_MEMWB   = 2'b01;
    localparam logic [1:0] FWD_EXMEM   = 2'b10;

    // Register-use metadata shadowing one pipeline register.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic                  uses_rt;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } hazard_slot_t;

    localparam hazard_slot_t EMPTY_SLOT = '0;

    // True when the slot's instruction will write register r (never $0).
    function automatic logic writes_reg(input hazard_slot_t s,
                                        input logic [REG_ADDR_W-1:0] r);
        return s.valid & s.reg_write & (s.rd != '0) & (s.rd == r);
    endfunction

endpackage

// File: rtl/forwarding_hazard_unit_if.sv
// ID-stage decode fields in, forwarding selects and stall controls out.
interface forwarding_hazard_unit_if;
    import mips_pkg::*;

    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rt;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic                  flush;

    logic [1:0]            forward_a;
    logic [1:0]            forward_b;
    logic                  stall;
    logic                  pc_write;
    logic                  ifid_write;
    logic                  idex_bubble;
    logic [CNT_W-1:0]      stall_count;

    // Pipeline side: supplies decode fields, consumes controls.
    modport master (
        output id_valid, id_rs, id_rt, id_uses_rt, id_rd,
               id_reg_write, id_mem_read, flush,
        input  forward_a, forward_b, stall, pc_write, ifid_write,
               idex_bubble, stall_count
    );

    // Hazard unit side.
    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rt, id_rd,
               id_reg_write, id_mem_read, flush,
        output forward_a, forward_b, stall, pc_write, ifid_write,
               idex_bubble, stall_count
    );

endinterface

// File: rtl/fwd_select.sv
// Per-operand forwarding comparator: picks the most recent in-flight writer
// of the source register, EX/MEM before MEM/WB, never forwarding $0.
module fwd_select
    import mips_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] i_src,
    input  logic                  i_use,
    input  hazard_slot_t          i_mem,
    input  hazard_slot_t          i_wb,
    output logic [1:0]            o_sel
);

    // Only destination/valid/write-enable of the later slots matter here.
    logic w_unused_fields;
    assign w_unused_fields = ^{i_mem.rs, i_mem.rt, i_mem.uses_rt, i_mem.mem_read,
                               i_wb.rs,  i_wb.rt,  i_wb.uses_rt,  i_wb.mem_read};

    // Priority select: newer result (EX/MEM) shadows the older one (MEM/WB).
    always_comb begin
        o_sel = FWD_REGFILE;
        if (i_use) begin
            if (writes_reg(i_mem, i_src)) begin
                o_sel = FWD_EXMEM;
            end else if (writes_reg(i_wb, i_src)) begin
                o_sel = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Forwarding and load-use hazard control for a 5-stage MIPS pipeline. Keeps
// its own shadow of ID/EX, EX/MEM and MEM/WB register-use metadata so only
// ID-stage decode fields are needed as inputs.
module forwarding_hazard_unit
    import mips_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    forwarding_hazard_unit_if.slave bus
);

    hazard_slot_t     r_s_ex;
    hazard_slot_t     r_s_mem;
    hazard_slot_t     r_s_wb;
    logic [CNT_W-1:0] r_stall_count;

    logic             w_rd_hit;
    logic             w_stall;
    logic             w_bubble;
    hazard_slot_t     w_id_slot;

    logic [REG_ADDR_W-1:0] w_src [2];
    logic                  w_use [2];
    logic [1:0]            w_sel [2];

    // Load-use detection against the load currently in EX; flush wins.
    always_comb begin
        w_rd_hit = (r_s_ex.rd == bus.id_rs) |
                   (bus.id_uses_rt & (r_s_ex.rd == bus.id_rt));
        w_stall  = bus.id_valid & ~bus.flush & r_s_ex.valid & r_s_ex.mem_read &
                   (r_s_ex.rd != '0) & w_rd_hit;
        w_bubble = w_stall | bus.flush;
    end

    // Slot image of the ID instruction; a bubble or squash enters as invalid.
    always_comb begin
        w_id_slot           = EMPTY_SLOT;
        w_id_slot.valid     = bus.id_valid & ~w_bubble;
        w_id_slot.rs        = bus.id_rs;
        w_id_slot.rt        = bus.id_rt;
        w_id_slot.uses_rt   = bus.id_uses_rt;
        w_id_slot.rd        = bus.id_rd;
        w_id_slot.reg_write = bus.id_reg_write;
        w_id_slot.mem_read  = bus.id_mem_read;
    end

    // Shadow pipeline advance; later stages always move, EX takes ID or a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s_ex  <= EMPTY_SLOT;
            r_s_mem <= EMPTY_SLOT;
            r_s_wb  <= EMPTY_SLOT;
        end else begin
            r_s_ex  <= w_id_slot;
            r_s_mem <= r_s_ex;
            r_s_wb  <= r_s_mem;
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    // Operand A reads rs whenever EX is valid; operand B reads rt only if used.
    always_comb begin
        w_src[0] = r_s_ex.rs;
        w_use[0] = r_s_ex.valid;
        w_src[1] = r_s_ex.rt;
        w_use[1] = r_s_ex.valid & r_s_ex.uses_rt;
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            fwd_select u_fwd_select (
                .i_src (w_src[gi]),
                .i_use (w_use[gi]),
                .i_mem (r_s_mem),
                .i_wb  (r_s_wb),
                .o_sel (w_sel[gi])
            );
        end
    endgenerate

    assign bus.forward_a   = w_sel[0];
    assign bus.forward_b   = w_sel[1];
    assign bus.stall       = w_stall;
    assign bus.pc_write    = ~w_stall;
    assign bus.ifid_write  = ~w_stall;
    assign bus.idex_bubble = w_bubble;
    assign bus.stall_count = r_stall_count;

endmodule
